// File: rtl/seg7_display_multi_if.sv
// ---------------------------------------------------------------------------
// seg7_display_multi_if
// Bundles the request/result signals of the multi-digit seven-segment
// converter so the converter and whatever drives it share one port.
//
// Signals:
//   value_in      - value to display, captured with update_req
//   mode_hex      - 1 = hexadecimal, 0 = decimal
//   signed_mode   - 1 = value_in is two's complement
//   blank_leading - 1 = blank leading zero digits
//   update_req    - start a conversion (honoured only when idle)
//   busy          - conversion in progress
//   overflow      - last completed conversion did not fit
//   hex_display   - DIGITS packed segment bytes, digit 0 in the low byte
//
// Modports: master drives the request side, slave is the converter.
// ---------------------------------------------------------------------------
interface seg7_display_multi_if #(
   parameter int DIGITS      = 6,
   parameter int VALUE_WIDTH = 16
);
   logic [VALUE_WIDTH-1:0] value_in;
   logic                   mode_hex;
   logic                   signed_mode;
   logic                   blank_leading;
   logic                   update_req;
   logic                   busy;
   logic                   overflow;
   logic [DIGITS*8-1:0]    hex_display;

   modport master (
      output value_in, mode_hex, signed_mode, blank_leading, update_req,
      input  busy, overflow, hex_display
   );

   modport slave (
      input  value_in, mode_hex, signed_mode, blank_leading, update_req,
      output busy, overflow, hex_display
   );
endinterface

// File: rtl/seg7_display_multi.sv
// ---------------------------------------------------------------------------
// seg7_display_multi
// Captures a binary value and converts it into DIGITS seven-segment patterns,
// either in hexadecimal or in decimal (iterative double-dabble, one bit per
// clock). Supports signed display, leading-zero blanking and an overflow
// indication (all dashes). The display keeps its old contents while a
// conversion runs and is replaced in one step when the conversion completes.
//
// Ports:
//   main_clk - sole clock
//   reset_n  - synchronous, active-low reset
//   bus      - slave side of seg7_display_multi_if (request inputs,
//              busy / overflow / hex_display outputs, all registered)
//
// Parameters:
//   DIGITS      - number of digits driven (>= 2)
//   VALUE_WIDTH - width of value_in (>= 4)
//   ACTIVE_LOW  - 1 inverts all 8 segment bits at the output
// ---------------------------------------------------------------------------
module seg7_display_multi #(
   parameter int DIGITS      = 6,
   parameter int VALUE_WIDTH = 16,
   parameter int ACTIVE_LOW  = 1
) (
   input logic                 main_clk,
   input logic                 reset_n,
   seg7_display_multi_if.slave bus
);

   localparam int BCD_W = DIGITS * 4;
   localparam int MAG_W = VALUE_WIDTH + 1;
   localparam int EXT_W = (MAG_W > BCD_W) ? MAG_W : BCD_W;
   localparam int CNT_W = $clog2(MAG_W + 1);

   localparam logic [CNT_W-1:0]    LAST_CNT  = CNT_W'(MAG_W - 1);
   localparam logic [7:0]          BLANK_SEG = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [DIGITS*8-1:0] BLANK_ALL = {DIGITS{BLANK_SEG}};

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      ENCODE
   } state_t;

   state_t             state;
   logic [MAG_W-1:0]   mag;
   logic [BCD_W-1:0]   bcd;
   logic               carry;
   logic               neg;
   logic               is_hex;
   logic               blank_lead;
   logic [CNT_W-1:0]   cnt;

   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   bcd_next;
   logic [MAG_W-1:0]   mag_next;
   logic               carry_next;

   logic [EXT_W-1:0]   mag_ext;
   logic [BCD_W-1:0]   nibbles;
   logic               hex_hi;
   int                 sig;
   logic               ovf_next;
   logic [7:0]         seg;
   logic [DIGITS*8-1:0] disp_next;

   // Active-high segment pattern for one hexadecimal nibble (dp unlit).
   function automatic logic [7:0] seg_code(input logic [3:0] n);
      case (n)
         4'h0: seg_code = 8'h3F;
         4'h1: seg_code = 8'h06;
         4'h2: seg_code = 8'h5B;
         4'h3: seg_code = 8'h4F;
         4'h4: seg_code = 8'h66;
         4'h5: seg_code = 8'h6D;
         4'h6: seg_code = 8'h7D;
         4'h7: seg_code = 8'h07;
         4'h8: seg_code = 8'h7F;
         4'h9: seg_code = 8'h6F;
         4'hA: seg_code = 8'h77;
         4'hB: seg_code = 8'h7C;
         4'hC: seg_code = 8'h39;
         4'hD: seg_code = 8'h5E;
         4'hE: seg_code = 8'h79;
         default: seg_code = 8'h71;
      endcase
   endfunction

   // One double-dabble step: every BCD nibble of 5 or more gets 3 added so
   // the following doubling carries correctly into the next decade, then the
   // whole {bcd, mag} pair moves left by one. A one leaving the top of the
   // BCD register means the value needs more digits than we have, and it is
   // remembered in the sticky carry.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      bcd_next   = {bcd_adj[BCD_W-2:0], mag[MAG_W-1]};
      mag_next   = {mag[MAG_W-2:0], 1'b0};
      carry_next = carry | bcd_adj[BCD_W-1];
   end

   // Final pattern build used on the ENCODE edge. The nibble source is the
   // BCD result in decimal mode or the raw magnitude in hex mode. The
   // magnitude is widened first so the hex overflow test (any bit above the
   // displayable nibbles) works whether the value is wider or narrower than
   // the display. The significant-digit count decides where blanking or the
   // minus sign starts; a negative value filling every digit leaves no room
   // for the minus and therefore counts as overflow.
   always_comb begin
      mag_ext   = EXT_W'(mag);
      nibbles   = is_hex ? mag_ext[BCD_W-1:0] : bcd;
      hex_hi    = (mag_ext >> BCD_W) != '0;
      sig       = 1;
      seg       = 8'h00;
      disp_next = '0;
      for (int i = 1; i < DIGITS; i++) begin
         if (nibbles[4*i +: 4] != 4'd0) begin
            sig = i + 1;
         end
      end
      ovf_next = (!is_hex && carry) || (is_hex && hex_hi) || (neg && (sig == DIGITS));
      for (int k = 0; k < DIGITS; k++) begin
         if (ovf_next) begin
            seg = 8'h40;
         end else if (k < sig) begin
            seg = seg_code(nibbles[4*k +: 4]);
         end else if (blank_lead) begin
            seg = (neg && (k == sig)) ? 8'h40 : 8'h00;
         end else begin
            seg = (neg && (k == DIGITS - 1)) ? 8'h40 : 8'h3F;
         end
         disp_next[8*k +: 8] = (ACTIVE_LOW != 0) ? ~seg : seg;
      end
   end

   // Control FSM and all registered outputs. IDLE captures the request and
   // forms the magnitude (one bit wider than the input so the most negative
   // value negates exactly). SHIFT runs the double-dabble for every
   // magnitude bit. ENCODE loads display and overflow together so the
   // outputs never show a partial result. Requests outside IDLE are simply
   // not looked at, so they are neither honoured nor queued.
   always_ff @(posedge main_clk) begin
      if (!reset_n) begin
         state           <= IDLE;
         mag             <= '0;
         bcd             <= '0;
         carry           <= 1'b0;
         neg             <= 1'b0;
         is_hex          <= 1'b0;
         blank_lead      <= 1'b0;
         cnt             <= '0;
         bus.busy        <= 1'b0;
         bus.overflow    <= 1'b0;
         bus.hex_display <= BLANK_ALL;
      end else begin
         case (state)
            IDLE: begin
               if (bus.update_req) begin
                  if (bus.signed_mode && bus.value_in[VALUE_WIDTH-1]) begin
                     mag <= -{bus.value_in[VALUE_WIDTH-1], bus.value_in};
                     neg <= 1'b1;
                  end else begin
                     mag <= {1'b0, bus.value_in};
                     neg <= 1'b0;
                  end
                  is_hex     <= bus.mode_hex;
                  blank_lead <= bus.blank_leading;
                  bcd        <= '0;
                  carry      <= 1'b0;
                  cnt        <= '0;
                  bus.busy   <= 1'b1;
                  state      <= bus.mode_hex ? ENCODE : SHIFT;
               end
            end
            SHIFT: begin
               bcd   <= bcd_next;
               mag   <= mag_next;
               carry <= carry_next;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST_CNT) begin
                  state <= ENCODE;
               end
            end
            ENCODE: begin
               bus.hex_display <= disp_next;
               bus.overflow    <= ovf_next;
               bus.busy        <= 1'b0;
               state           <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_display_multi.sv
// ---------------------------------------------------------------------------
// tb_seg7_display_multi
// Drives three converter instances with identical requests:
//   u0: DIGITS=6, ACTIVE_LOW=0   u1: DIGITS=4, ACTIVE_LOW=1
//   u2: DIGITS=6, ACTIVE_LOW=1   (all VALUE_WIDTH=16)
// Expected results come from an arithmetic reference model (division by the
// display base) and are queued per instance; a monitor pops them whenever an
// instance finishes a conversion and also checks that outputs hold between
// completions.
// ---------------------------------------------------------------------------
module tb_seg7_display_multi;

   localparam int VW = 16;
   localparam int NI = 3;
   localparam int DIG [NI] = '{6, 4, 6};
   localparam bit AL  [NI] = '{1'b0, 1'b1, 1'b1};

   typedef struct {
      logic [47:0] disp;
      bit          ovf;
      int          lat;
   } exp_t;

   logic main_clk;
   logic reset_n;

   logic [VW-1:0] value_in;
   logic          mode_hex;
   logic          signed_mode;
   logic          blank_leading;
   logic          update_req;

   int checks;
   int errors;
   bit mon_en;

   exp_t        sb_q [NI][$];
   exp_t        last_exp [NI];
   bit          prev_busy [NI];
   int          busy_cnt [NI];

   logic        busy_w [NI];
   logic        ovf_w  [NI];
   logic [47:0] disp_w [NI];

   seg7_display_multi_if #(.DIGITS(6), .VALUE_WIDTH(VW)) bus0 ();
   seg7_display_multi_if #(.DIGITS(4), .VALUE_WIDTH(VW)) bus1 ();
   seg7_display_multi_if #(.DIGITS(6), .VALUE_WIDTH(VW)) bus2 ();

   seg7_display_multi #(.DIGITS(6), .VALUE_WIDTH(VW), .ACTIVE_LOW(0)) u0 (
      .main_clk (main_clk),
      .reset_n  (reset_n),
      .bus      (bus0)
   );
   seg7_display_multi #(.DIGITS(4), .VALUE_WIDTH(VW), .ACTIVE_LOW(1)) u1 (
      .main_clk (main_clk),
      .reset_n  (reset_n),
      .bus      (bus1)
   );
   seg7_display_multi #(.DIGITS(6), .VALUE_WIDTH(VW), .ACTIVE_LOW(1)) u2 (
      .main_clk (main_clk),
      .reset_n  (reset_n),
      .bus      (bus2)
   );

   // Every instance sees the same request inputs.
   assign bus0.value_in      = value_in;
   assign bus0.mode_hex      = mode_hex;
   assign bus0.signed_mode   = signed_mode;
   assign bus0.blank_leading = blank_leading;
   assign bus0.update_req    = update_req;
   assign bus1.value_in      = value_in;
   assign bus1.mode_hex      = mode_hex;
   assign bus1.signed_mode   = signed_mode;
   assign bus1.blank_leading = blank_leading;
   assign bus1.update_req    = update_req;
   assign bus2.value_in      = value_in;
   assign bus2.mode_hex      = mode_hex;
   assign bus2.signed_mode   = signed_mode;
   assign bus2.blank_leading = blank_leading;
   assign bus2.update_req    = update_req;

   // Flatten the outputs so one monitor loop can handle all instances.
   assign busy_w[0] = bus0.busy;
   assign busy_w[1] = bus1.busy;
   assign busy_w[2] = bus2.busy;
   assign ovf_w[0]  = bus0.overflow;
   assign ovf_w[1]  = bus1.overflow;
   assign ovf_w[2]  = bus2.overflow;
   assign disp_w[0] = bus0.hex_display;
   assign disp_w[1] = {16'h0000, bus1.hex_display};
   assign disp_w[2] = bus2.hex_display;

   // Free-running clock.
   initial begin
      main_clk = 1'b0;
      forever #5 main_clk = ~main_clk;
   end

   // Active-high glyphs for the values 0..15.
   function automatic logic [7:0] glyph(input int n);
      logic [7:0] tbl [16];
      tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
      return tbl[n];
   endfunction

   function automatic logic [47:0] blank_of(input int digits, input bit al);
      logic [47:0] r;
      r = '0;
      for (int k = 0; k < digits; k++) r[8*k +: 8] = al ? 8'hFF : 8'h00;
      return r;
   endfunction

   // Reference model: magnitude and sign from plain integer arithmetic, the
   // digits by repeated division in the display base, overflow when the
   // magnitude reaches base**digits or the minus has no digit left.
   function automatic exp_t model(input int digits, input bit al, input logic [VW-1:0] v,
                                  input bit hx, input bit sg, input bit bl);
      exp_t       e;
      longint     mag;
      longint     tmp;
      longint     lim;
      bit         neg;
      bit         ovf;
      int         base;
      int         s;
      int         d [8];
      logic [7:0] g;
      neg  = sg && v[VW-1];
      mag  = neg ? (longint'(65536) - longint'(v)) : longint'(v);
      base = hx ? 16 : 10;
      lim  = 1;
      for (int k = 0; k < digits; k++) lim = lim * base;
      ovf = (mag >= lim);
      tmp = mag;
      for (int k = 0; k < digits; k++) begin
         d[k] = int'(tmp % base);
         tmp  = tmp / base;
      end
      s = 1;
      for (int k = 0; k < digits; k++) if (d[k] != 0) s = k + 1;
      if (neg && s == digits) ovf = 1'b1;
      e.disp = '0;
      for (int k = 0; k < digits; k++) begin
         if (ovf)        g = 8'h40;
         else if (k < s) g = glyph(d[k]);
         else if (bl)    g = (neg && k == s) ? 8'h40 : 8'h00;
         else            g = (neg && k == digits - 1) ? 8'h40 : 8'h3F;
         e.disp[8*k +: 8] = al ? ~g : g;
      end
      e.ovf = ovf;
      e.lat = hx ? 1 : VW + 2;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [47:0] actual,
                              input logic [47:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic pushAll(input logic [VW-1:0] v, input bit hx, input bit sg, input bit bl);
      for (int i = 0; i < NI; i++) sb_q[i].push_back(model(DIG[i], AL[i], v, hx, sg, bl));
   endtask

   // Forget everything the monitor knew; all instances are freshly reset.
   task automatic clearMonitor();
      for (int i = 0; i < NI; i++) begin
         sb_q[i].delete();
         last_exp[i].disp = blank_of(DIG[i], AL[i]);
         last_exp[i].ovf  = 1'b0;
         last_exp[i].lat  = 0;
         prev_busy[i]     = 1'b0;
         busy_cnt[i]      = 0;
      end
   endtask

   task automatic checkResetState(input string tag);
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("%s_busy%0d", tag, i), 48'(busy_w[i]), 48'd0);
         checkOutput($sformatf("%s_ovf%0d", tag, i), 48'(ovf_w[i]), 48'd0);
         checkOutput($sformatf("%s_disp%0d", tag, i), disp_w[i], blank_of(DIG[i], AL[i]));
      end
   endtask

   // One request. With noisy=1 the inputs are scrambled and update_req is
   // pulsed at random while the conversion runs; none of that may matter.
   task automatic applyStimulus(input logic [VW-1:0] v, input bit hx, input bit sg,
                                input bit bl, input bit noisy);
      int guard;
      @(negedge main_clk);
      value_in      = v;
      mode_hex      = hx;
      signed_mode   = sg;
      blank_leading = bl;
      update_req    = 1'b1;
      pushAll(v, hx, sg, bl);
      @(negedge main_clk);
      update_req = 1'b0;
      guard = 0;
      while (busy_w[0] && guard < 40) begin
         if (noisy) begin
            value_in      = VW'($urandom);
            mode_hex      = 1'($urandom);
            signed_mode   = 1'($urandom);
            blank_leading = 1'($urandom);
            update_req    = 1'($urandom);
         end
         @(negedge main_clk);
         guard++;
      end
      update_req = 1'b0;
      checkOutput("done_timeout", 48'(guard >= 40), 48'd0);
   endtask

   // Scoreboard monitor: a busy falling edge is a completion and must match
   // the oldest queued expectation (display, overflow, latency); at every
   // other sample the outputs must still hold the last completed result.
   always @(negedge main_clk) begin
      if (mon_en) begin
         for (int i = 0; i < NI; i++) begin
            if (busy_w[i]) busy_cnt[i]++;
            if (prev_busy[i] && !busy_w[i]) begin
               if (sb_q[i].size() == 0) begin
                  checkOutput($sformatf("unexpected_done%0d", i), 48'd1, 48'd0);
               end else begin
                  exp_t e;
                  e = sb_q[i].pop_front();
                  checkOutput($sformatf("disp%0d", i), disp_w[i], e.disp);
                  checkOutput($sformatf("ovf%0d", i), 48'(ovf_w[i]), 48'(e.ovf));
                  checkOutput($sformatf("latency%0d", i), 48'(busy_cnt[i]), 48'(e.lat));
                  last_exp[i] = e;
               end
               busy_cnt[i] = 0;
            end else begin
               checkOutput($sformatf("hold_disp%0d", i), disp_w[i], last_exp[i].disp);
               checkOutput($sformatf("hold_ovf%0d", i), 48'(ovf_w[i]), 48'(last_exp[i].ovf));
            end
            prev_busy[i] = busy_w[i];
         end
      end
   end

   initial begin
      int guard;
      int falls;
      bit pb;
      logic [31:0] r;
      checks        = 0;
      errors        = 0;
      mon_en        = 1'b0;
      reset_n       = 1'b0;
      value_in      = '0;
      mode_hex      = 1'b0;
      signed_mode   = 1'b0;
      blank_leading = 1'b0;
      update_req    = 1'b0;
      clearMonitor();
      repeat (3) @(negedge main_clk);
      checkResetState("reset");
      reset_n = 1'b1;
      mon_en  = 1'b1;
      repeat (2) @(negedge main_clk);

      $display("[TB] directed requests");
      applyStimulus(16'd12345, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(16'hFFD6,  1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(16'hBEEF,  1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h8000,  1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(16'h8000,  1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'd0,     1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(16'd9999,  1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'hFFFF,  1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'd12345, 1'b0, 1'b0, 1'b1, 1'b1);

      // update_req held high across completion re-captures immediately.
      $display("[TB] held request");
      @(negedge main_clk);
      value_in      = 16'd321;
      mode_hex      = 1'b0;
      signed_mode   = 1'b0;
      blank_leading = 1'b0;
      update_req    = 1'b1;
      pushAll(16'd321, 1'b0, 1'b0, 1'b0);
      pushAll(16'd321, 1'b0, 1'b0, 1'b0);
      guard = 0;
      falls = 0;
      pb    = 1'b0;
      while (falls < 2 && guard < 100) begin
         @(negedge main_clk);
         if (pb && !busy_w[0]) falls++;
         pb = busy_w[0];
         guard++;
      end
      update_req = 1'b0;
      checkOutput("held_timeout", 48'(guard >= 100), 48'd0);
      repeat (2) @(negedge main_clk);

      // Reset during SHIFT discards the conversion for good.
      $display("[TB] reset mid-conversion");
      @(negedge main_clk);
      value_in   = 16'd4321;
      mode_hex   = 1'b0;
      update_req = 1'b1;
      @(negedge main_clk);
      update_req = 1'b0;
      repeat (5) @(negedge main_clk);
      mon_en  = 1'b0;
      reset_n = 1'b0;
      @(negedge main_clk);
      checkResetState("midreset");
      reset_n = 1'b1;
      clearMonitor();
      mon_en = 1'b1;
      repeat (25) @(negedge main_clk);
      checkResetState("afterreset");

      $display("[TB] random requests");
      for (int n = 0; n < 150; n++) begin
         r = $urandom & ((32'd1 << $urandom_range(1, 16)) - 32'd1);
         applyStimulus(r[VW-1:0], 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      repeat (3) @(negedge main_clk);

      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("sb_empty%0d", i), 48'(sb_q[i].size()), 48'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
